refresh_scheduler: RTL
======================

Name: refresh_scheduler

Overview:
- Downstream consumer of the free-running 16-bit binary counter in memctrl.
- Derives periodic refresh ticks from the count value and queues them as pending refreshes.
- Issues them to the memory controller command path over a req/ack handshake.
- Flags urgency and overflow so the arbiter can prioritise refresh over traffic.

Parameters:
- CNT_W, 16: width of the incoming counter value.
- REF_INTERVAL, 64: counter ticks between refresh obligations. Range 1..2^(CNT_W-1).
- MAX_PEND, 8: maximum queued (postponed) refreshes.
- URGENT_TH, 6: pending count at or above which ref_urgent asserts. Must be ≤ MAX_PEND.
- PEND_W, 4: width of the pending counter. Must hold MAX_PEND.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scheduler enable.
- binary  in  CNT_W  free-running count from the upstream binary counter (+1 per clk).
- ref_ack  in  1  controller accepted the current refresh.
- ref_req  out  1  refresh request.
- ref_urgent  out  1  pending ≥ URGENT_TH.
- pend_cnt  out  PEND_W  queued refresh count.
- ovf_err  out  1  sticky: a tick was lost because the queue was full.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: ref_req=0, ref_urgent=0, pend_cnt=0, ovf_err=0, last_mark=0, en_d=0, FSM=IDLE.
- Enable resync: on the cycle en is sampled 1 with en_d=0, last_mark <= binary. No tick is generated that cycle.
- While en=0: no ticks are generated. Queued refreshes still drain via the handshake.
- Tick detection: delta = (binary - last_mark) mod 2^CNT_W, computed CNT_W-bit unsigned, so counter wrap is transparent.
  - tick = en & en_d & (delta ≥ REF_INTERVAL).
  - On tick, last_mark <= last_mark + REF_INTERVAL (mod 2^CNT_W). Drift-free, at most one tick per cycle.
- Pending counter:
  - Tick only: +1.
  - Accepted ack only: -1.
  - Tick and accepted ack in the same cycle: unchanged.
  - Tick with pend_cnt==MAX_PEND and no ack: pend_cnt holds and ovf_err <= 1.
  - ovf_err is sticky until rst.
- ref_urgent is registered: (next pend_cnt ≥ URGENT_TH).
- FSM states IDLE, REQ, GAP:
  - IDLE: ref_req=0. If pend_cnt>0, go to REQ.
  - REQ: ref_req=1, held stable until ref_ack=1. Then pend_cnt decrements and the FSM goes to GAP.
  - GAP: ref_req=0 for exactly one cycle, then IDLE. Guarantees a deassert between back-to-back refreshes.
- ref_ack is accepted only in REQ. An ack in IDLE/GAP is ignored.
- Latency: tick in cycle N → pend_cnt updated at N+1 → ref_req high at N+2 (from IDLE). Minimum period between two requests is 3 cycles.
- Reset mid-handshake: everything returns to reset values immediately (async). The pending queue is discarded.

Optional Feature:
- Macro: REF_STAT_EN.
- Defined:
  - Adds output stat_issued[15:0]: saturating count of accepted refreshes (+1 per accepted ack, holds at 16'hFFFF).
  - Adds output stat_peak[PEND_W-1:0]: highest pend_cnt reached.
  - Both reset to 0.
- Undefined: neither port nor its logic exists. Core behaviour is identical.

Decomposition:
- Package memctrl_ref_pkg:
  - FSM state typedef (IDLE/REQ/GAP, 2-bit encoding).
  - Default constants for REF_INTERVAL, MAX_PEND, URGENT_TH.
- Sub-module ref_tick_gen:
  - Contains en_d, last_mark, modular delta compare and tick output.
  - Ports: clk, rst, en, binary, tick.
- FSM, pending counter and stats live in refresh_scheduler.

Test Plan (REF_INTERVAL=64, MAX_PEND=8, URGENT_TH=6):
- Basic tick: rst 1→0, en=1 at binary=0x0010, ack 2 cycles after req → first ref_req when binary=0x0050+2; pend_cnt returns 0; next req 64 cycles later.
- Wrap-around: en rises at binary=0xFFE0 → tick at binary=0x0020 (delta 64 across the wrap); exactly one tick, no spurious extra.
- Backpressure/urgency: ref_ack=0 for 6×64 cycles → pend_cnt=6 and ref_urgent=1. Release ack every cycle in REQ → requests separated by a GAP cycle, pend_cnt drains to 0 and ref_urgent clears.
- Overflow: ref_ack=0 for 9×64 cycles → pend_cnt saturates at 8, ovf_err=1. ovf_err stays 1 after draining until rst.
- Simultaneous tick and ack with pend_cnt=3 → pend_cnt stays 3. Ack pulsed in IDLE/GAP → ignored, no decrement.
- Reset mid-REQ: assert rst while ref_req=1 and pend_cnt=5 → ref_req, pend_cnt, ovf_err go 0 in the same cycle. With REF_STAT_EN, stat_issued=0.

Source files
------------

// File: rtl/memctrl_ref_pkg.sv
// Shared types and default constants for the memory-controller refresh scheduler.
package memctrl_ref_pkg;

    // Request handshake states: wait for work, hold request, forced deassert cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } ref_state_t;

    localparam int REF_INTERVAL_DEF = 64;
    localparam int MAX_PEND_DEF     = 8;
    localparam int URGENT_TH_DEF    = 6;

endpackage

// File: rtl/ref_tick_gen.sv
// Derives drift-free refresh ticks from a free-running counter value.
// The mark advances by exactly REF_INTERVAL per tick, so late detection never accumulates
// drift. The modular subtraction makes the counter wrap transparent.
module ref_tick_gen #(
    parameter int CNT_W        = 16,
    parameter int REF_INTERVAL = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] binary,
    output logic             tick
);

    localparam logic [CNT_W-1:0] INTERVAL = CNT_W'(REF_INTERVAL);

    logic             en_d;
    logic [CNT_W-1:0] last_mark;
    logic [CNT_W-1:0] delta;

    assign delta = binary - last_mark;
    assign tick  = en & en_d & (delta >= INTERVAL);

    // Resync the mark on enable rise, otherwise step it one interval per tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_d      <= 1'b0;
            last_mark <= '0;
        end else begin
            en_d <= en;
            if (en & ~en_d)
                last_mark <= binary;
            else if (tick)
                last_mark <= last_mark + INTERVAL;
        end
    end

endmodule

// File: rtl/refresh_scheduler.sv
// Refresh scheduler: queues periodic refresh obligations and issues them over req/ack.
// Optional macro REF_STAT_EN adds stat_issued (saturating accepted count) and
// stat_peak (highest pending count seen).
module refresh_scheduler
    import memctrl_ref_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int MAX_PEND     = MAX_PEND_DEF,
    parameter int URGENT_TH    = URGENT_TH_DEF,
    parameter int PEND_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  binary,
    input  logic              ref_ack,
    output logic              ref_req,
    output logic              ref_urgent,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf_err
`ifdef REF_STAT_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [PEND_W-1:0] stat_peak
`endif
);

    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
    localparam logic [PEND_W-1:0] PEND_URG = PEND_W'(URGENT_TH);

    ref_state_t        state, state_nxt;
    logic              tick;
    logic              accept;
    logic              ovf_set;
    logic [PEND_W-1:0] pend_nxt;

    ref_tick_gen #(
        .CNT_W        (CNT_W),
        .REF_INTERVAL (REF_INTERVAL)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .binary (binary),
        .tick   (tick)
    );

    // An ack only counts while a request is actually outstanding.
    assign accept = (state == ST_REQ) & ref_ack;

    // Pending queue arithmetic; a tick into a full queue is dropped and flagged.
    always_comb begin
        pend_nxt = pend_cnt;
        ovf_set  = 1'b0;
        if (tick & ~accept) begin
            if (pend_cnt == PEND_MAX)
                ovf_set = 1'b1;
            else
                pend_nxt = pend_cnt + 1'b1;
        end else if (accept & ~tick) begin
            pend_nxt = pend_cnt - 1'b1;
        end
    end

    // Pending count, registered urgency and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt   <= '0;
            ref_urgent <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            pend_cnt   <= pend_nxt;
            ref_urgent <= (pend_nxt >= PEND_URG);
            ovf_err    <= ovf_err | ovf_set;
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and request output; GAP forces one low cycle between requests.
    always_comb begin
        state_nxt = state;
        ref_req   = 1'b0;
        case (state)
            ST_IDLE: if (pend_cnt != '0) state_nxt = ST_REQ;
            ST_REQ: begin
                ref_req = 1'b1;
                if (ref_ack) state_nxt = ST_GAP;
            end
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef REF_STAT_EN
    // Saturating issued count and high-water mark of the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued <= '0;
            stat_peak   <= '0;
        end else begin
            if (accept && stat_issued != 16'hFFFF)
                stat_issued <= stat_issued + 16'd1;
            if (pend_nxt > stat_peak)
                stat_peak <= pend_nxt;
        end
    end
`endif

endmodule
